// File: rtl/regfile_debug_dumper_pkg.sv
// Shared constants, FSM encoding and index-byte format for the register dump path.
// Build option: REGDUMP_INDEX_EN prefixes each register's bytes with an index byte.
package regfile_debug_dumper_pkg;
  localparam int DEF_NUM_REGS = 32;
  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 32;
`ifdef REGDUMP_INDEX_EN
  localparam int BYTES_PER_REG = DATA_W / 8 + 1;
`else
  localparam int BYTES_PER_REG = DATA_W / 8;
`endif
  localparam int SHIFT_W = BYTES_PER_REG * 8;
  localparam int CNT_W   = $clog2(BYTES_PER_REG + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2,
    ST_SEND  = 2'd3
  } state_t;

  function automatic logic [7:0] index_byte(input logic [ADDR_W-1:0] addr);
    return {{(8 - ADDR_W){1'b0}}, addr};
  endfunction
endpackage

// File: rtl/regfile_debug_dumper_if.sv
// Control, register-file debug port and byte stream of the register dumper.
interface regfile_debug_dumper_if;
  import regfile_debug_dumper_pkg::*;

  logic              start;
  logic              dump_all;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] read_address_debug;
  logic [DATA_W-1:0] data_out_debug;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, dump_all, sel_addr, data_out_debug, tx_ready,
    output read_address_debug, tx_data, tx_valid, busy, done
  );

  modport slave (
    output start, dump_all, sel_addr, data_out_debug, tx_ready,
    input  read_address_debug, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/regdump_byte_serializer.sv
// Loads one register word (plus optional index byte) and streams it MSB-first
// on a valid/ready byte interface; flags the final byte to the controlling FSM.
module regdump_byte_serializer
  import regfile_debug_dumper_pkg::*;
(
  input  logic               clock_debug,
  input  logic               reset,
  input  logic               load,
  input  logic [SHIFT_W-1:0] load_word,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  output logic               last_byte
);
  logic [SHIFT_W-1:0] shift_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               valid_r;

  // Shift register, byte counter and valid flag; nothing moves while stalled.
  always_ff @(posedge clock_debug or posedge reset) begin
    if (reset) begin
      shift_r <= '0;
      cnt_r   <= '0;
      valid_r <= 1'b0;
    end else if (load) begin
      shift_r <= load_word;
      cnt_r   <= CNT_W'(BYTES_PER_REG);
      valid_r <= 1'b1;
    end else if (valid_r && tx_ready) begin
      shift_r <= {shift_r[SHIFT_W-9:0], 8'h00};
      cnt_r   <= cnt_r - CNT_W'(1);
      valid_r <= (cnt_r != CNT_W'(1));
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
      valid_r <= valid_r;
    end
  end

  assign tx_data   = shift_r[SHIFT_W-1 -: 8];
  assign tx_valid  = valid_r;
  assign last_byte = (cnt_r == CNT_W'(1));
endmodule

// File: rtl/regfile_debug_dumper.sv
// Debug-domain register dumper: fetches registers through the debug read port and
// serialises them to the UART byte stream. Build option: REGDUMP_INDEX_EN.
module regfile_debug_dumper
  import regfile_debug_dumper_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic                    clock_debug,
  input  logic                    reset,
  regfile_debug_dumper_if.master  dbg
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t             state_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [ADDR_W-1:0]  end_r;
  logic               busy_r;
  logic               done_r;
  logic               load_s;
  logic               fire_s;
  logic               last_byte_s;
  logic               tx_valid_s;
  logic [7:0]         tx_data_s;
  logic [SHIFT_W-1:0] load_word_s;

`ifdef REGDUMP_INDEX_EN
  assign load_word_s = {index_byte(addr_r), dbg.data_out_debug};
`else
  assign load_word_s = dbg.data_out_debug;
`endif

  assign load_s = (state_r == ST_LATCH);
  assign fire_s = tx_valid_s && dbg.tx_ready;

  // Dump sequencer: the address is re-fetched for every register, the port has no hold.
  always_ff @(posedge clock_debug or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      end_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (dbg.start) begin
            state_r <= ST_FETCH;
            addr_r  <= dbg.dump_all ? '0 : dbg.sel_addr;
            end_r   <= dbg.dump_all ? LAST_ADDR : dbg.sel_addr;
            busy_r  <= 1'b1;
          end
        end
        ST_FETCH: state_r <= ST_LATCH;
        ST_LATCH: state_r <= ST_SEND;
        ST_SEND: begin
          if (fire_s && last_byte_s) begin
            if (addr_r == end_r) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_FETCH;
              addr_r  <= addr_r + ADDR_W'(1);
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  regdump_byte_serializer u_serializer (
    .clock_debug (clock_debug),
    .reset       (reset),
    .load        (load_s),
    .load_word   (load_word_s),
    .tx_ready    (dbg.tx_ready),
    .tx_data     (tx_data_s),
    .tx_valid    (tx_valid_s),
    .last_byte   (last_byte_s)
  );

  assign dbg.read_address_debug = addr_r;
  assign dbg.tx_data            = tx_data_s;
  assign dbg.tx_valid           = tx_valid_s;
  assign dbg.busy               = busy_r;
  assign dbg.done               = done_r;
endmodule
